// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone responder backed by a single-port 32-bit word memory.
// Serves instruction fetches, loads and stores from the shared CPU bus.
// Each accepted access terminates after WAIT_STATES extra cycles with a
// one-cycle ack or err pulse.
//
// Ports:
//   i_clk      clock
//   i_reset    synchronous, active-high reset
//   i_wb_cyc   bus cycle active
//   i_wb_stb   per-byte-lane strobe/select (stb[0] = bits 7:0)
//   i_wb_we    1 = write, 0 = read
//   i_wb_addr  byte address, bits [1:0] ignored
//   i_wb_dat   write data
//   o_wb_dat   read data, holds until the next successful read
//   o_wb_ack   successful termination pulse
//   o_wb_err   error termination pulse
//
// Optional feature macro: WB_MEM_ERR_CHECK_EN
//   defined   : out-of-range addresses and illegal strobe patterns end in err
//   undefined : err is never raised, addresses wrap modulo the depth and any
//               nonzero strobe is used as a raw lane mask
//
// WAIT_STATES is limited to 0..15.

module wb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic [3:0]  i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [31:0]             addr_q;
    logic                    we_q;
    logic [3:0]              stb_q;
    logic [31:0]             wdat_q;
    logic [31:0]             dat_q;
    logic                    ack_q;
    logic                    err_q;

    logic [31:0]             mem_q [DEPTH];

    logic                    req_c;
    logic                    in_idle_c;
    logic [31:0]             acc_addr_c;
    logic                    acc_we_c;
    logic [3:0]              acc_stb_c;
    logic [31:0]             acc_dat_c;
    logic [ADDR_WIDTH-1:0]   idx_c;
    logic                    enter_resp_c;
    logic                    err_c;
    logic                    unused_addr_c;

    // Access attributes: live bus values on the accepting edge, latched copies afterwards.
    always_comb begin
        req_c        = i_wb_cyc && (i_wb_stb != 4'b0000);
        in_idle_c    = (state_q == S_IDLE);
        acc_addr_c   = in_idle_c ? i_wb_addr : addr_q;
        acc_we_c     = in_idle_c ? i_wb_we   : we_q;
        acc_stb_c    = in_idle_c ? i_wb_stb  : stb_q;
        acc_dat_c    = in_idle_c ? i_wb_dat  : wdat_q;
        idx_c        = acc_addr_c[ADDR_WIDTH+1:2];
        // The edge that moves the FSM into RESP is where data is read or committed.
        enter_resp_c = (in_idle_c && req_c && (WAIT_STATES == 0)) ||
                       ((state_q == S_WAIT) && i_wb_cyc && (cnt_q == CNT_W'(0)));
    end

    // Error decode for the access currently being terminated.
`ifdef WB_MEM_ERR_CHECK_EN
    always_comb begin
        err_c = 1'b0;
        if ((acc_addr_c >> (ADDR_WIDTH + 2)) != 32'd0) begin
            err_c = 1'b1;
        end
        case (acc_stb_c)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ;
            default: err_c = 1'b1;
        endcase
    end
`else
    assign err_c = 1'b0;
`endif

    // Byte-offset bits and (without range checking) the upper address bits are don't-cares.
    assign unused_addr_c = ^acc_addr_c;

    // Control FSM with registered terminations and read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            stb_q   <= '0;
            wdat_q  <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        addr_q <= i_wb_addr;
                        we_q   <= i_wb_we;
                        stb_q  <= i_wb_stb;
                        wdat_q <= i_wb_dat;
                        if (WAIT_STATES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    // Dropping cyc abandons the access without any termination.
                    if (!i_wb_cyc) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(0)) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A still-asserted cycle is never served twice.
                    if (!i_wb_cyc) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (enter_resp_c) begin
                ack_q <= !err_c;
                err_q <= err_c;
                if (!acc_we_c && !err_c) begin
                    dat_q <= mem_q[idx_c];
                end
            end
        end
    end

    // Storage: byte-lane write on the edge entering RESP; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && enter_resp_c && acc_we_c && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_stb_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= acc_dat_c[8*b +: 8];
                end
            end
        end
    end

    assign o_wb_dat = dat_q;
    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: directed test of wb_mem_slave with two instances,
// one with WAIT_STATES=0 (index 0) and one with WAIT_STATES=3 (index 1).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_wb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc  [2];
    logic [3:0]  stb  [2];
    logic        we   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wb_cyc  (cyc[0]),
        .i_wb_stb  (stb[0]),
        .i_wb_we   (we[0]),
        .i_wb_addr (addr[0]),
        .i_wb_dat  (wdat[0]),
        .o_wb_dat  (rdat[0]),
        .o_wb_ack  (ack[0]),
        .o_wb_err  (err[0])
    );

    wb_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wb_cyc  (cyc[1]),
        .i_wb_stb  (stb[1]),
        .i_wb_we   (we[1]),
        .i_wb_addr (addr[1]),
        .i_wb_dat  (wdat[1]),
        .o_wb_dat  (rdat[1]),
        .o_wb_ack  (ack[1]),
        .o_wb_err  (err[1])
    );

    // Drives one access, holds cyc for 8 cycles, then drops it. Reports the
    // cycle of the first termination (-1 if none), the ack/err pulse counts
    // and the read data seen with the ack.
    task automatic run_access(input int d, input logic w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] dw,
                              output int term_cyc, output int ack_n,
                              output int err_n, output logic [31:0] rd);
        term_cyc = -1;
        ack_n    = 0;
        err_n    = 0;
        rd       = 32'h0;
        @(negedge clk);
        cyc[d]  = 1'b1;
        stb[d]  = s;
        we[d]   = w;
        addr[d] = a;
        wdat[d] = dw;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                ack_n++;
                if (term_cyc < 0) begin
                    term_cyc = c;
                    rd = rdat[d];
                end
            end
            if (err[d] === 1'b1) begin
                err_n++;
                if (term_cyc < 0) term_cyc = c;
            end
        end
        cyc[d] = 1'b0;
        stb[d] = 4'b0000;
        we[d]  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 4'b0000; we[d] = 1'b0;
            addr[d] = 32'h0; wdat[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0) begin $display("FAIL reset_ack[%0d]: got %b want 0", d, ack[d]); n_fail++; end
            n_checks++;
            if (err[d] !== 1'b0) begin $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); n_fail++; end
            n_checks++;
            if (rdat[d] !== 32'h0) begin $display("FAIL reset_dat[%0d]: got %h want 0", d, rdat[d]); n_fail++; end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int t, na, ne; logic [31:0] rd;
        run_access(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, t, na, ne, rd);
        n_checks++;
        if (t !== 1) begin $display("FAIL wr0_latency: got %0d want 1", t); n_fail++; end
        n_checks++;
        if (na !== 1 || ne !== 0) begin $display("FAIL wr0_term: got ack=%0d err=%0d want ack=1 err=0", na, ne); n_fail++; end
        run_access(0, 1'b0, 32'h10, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (t !== 1) begin $display("FAIL rd0_latency: got %0d want 1", t); n_fail++; end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin $display("FAIL rd0_data: got %h want deadbeef", rd); n_fail++; end
        n_checks++;
        if (ne !== 0) begin $display("FAIL rd0_err: got %0d want 0", ne); n_fail++; end
    endtask

    task automatic test_byte_lanes;
        int t, na, ne; logic [31:0] rd;
        run_access(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, t, na, ne, rd);
        n_checks++;
        if (na !== 1) begin $display("FAIL lane0_ack: got %0d want 1", na); n_fail++; end
        run_access(0, 1'b1, 32'h10, 4'b1000, 32'h55000000, t, na, ne, rd);
        n_checks++;
        if (na !== 1) begin $display("FAIL lane3_ack: got %0d want 1", na); n_fail++; end
        run_access(0, 1'b0, 32'h10, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (rd !== 32'h55ADBEAA) begin $display("FAIL lanes_data: got %h want 55adbeaa", rd); n_fail++; end
    endtask

    task automatic test_wait_states;
        int t, na, ne; logic [31:0] rd;
        run_access(1, 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, t, na, ne, rd);
        n_checks++;
        if (t !== 4) begin $display("FAIL ws_wr_latency: got %0d want 4", t); n_fail++; end
        run_access(1, 1'b0, 32'h20, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (t !== 4) begin $display("FAIL ws_rd_latency: got %0d want 4", t); n_fail++; end
        n_checks++;
        if (na !== 1 || ne !== 0) begin $display("FAIL ws_drain_single: got ack=%0d err=%0d want ack=1 err=0", na, ne); n_fail++; end
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin $display("FAIL ws_rd_data: got %h want cafef00d", rd); n_fail++; end
    endtask

    task automatic test_abort;
        int t, na, ne, seen; logic [31:0] rd;
        seen = 0;
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 4'b1111; we[1] = 1'b1;
        addr[1] = 32'h20; wdat[1] = 32'h12345678;
        repeat (2) begin
            @(negedge clk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen++;
        end
        cyc[1] = 1'b0; stb[1] = 4'b0000; we[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin $display("FAIL abort_term: got %0d termination cycles want 0", seen); n_fail++; end
        run_access(1, 1'b0, 32'h20, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin $display("FAIL abort_mem: got %h want cafef00d", rd); n_fail++; end
    endtask

    task automatic test_error;
        int t, na, ne; logic [31:0] rd;
`ifdef WB_MEM_ERR_CHECK_EN
        run_access(0, 1'b0, 32'h00001000, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (ne !== 1 || na !== 0) begin $display("FAIL err_range: got ack=%0d err=%0d want ack=0 err=1", na, ne); n_fail++; end
        n_checks++;
        if (t !== 1) begin $display("FAIL err_range_latency: got %0d want 1", t); n_fail++; end
        n_checks++;
        if (rdat[0] !== 32'h55ADBEAA) begin $display("FAIL err_rd_hold: got %h want 55adbeaa", rdat[0]); n_fail++; end
        run_access(0, 1'b1, 32'h10, 4'b0110, 32'hFFFFFFFF, t, na, ne, rd);
        n_checks++;
        if (ne !== 1 || na !== 0) begin $display("FAIL err_stb: got ack=%0d err=%0d want ack=0 err=1", na, ne); n_fail++; end
        run_access(0, 1'b0, 32'h10, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (rd !== 32'h55ADBEAA) begin $display("FAIL err_mem: got %h want 55adbeaa", rd); n_fail++; end
`else
        run_access(0, 1'b1, 32'h0, 4'b1111, 32'h0BADCAFE, t, na, ne, rd);
        run_access(0, 1'b0, 32'h00001000, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (na !== 1 || ne !== 0) begin $display("FAIL alias_term: got ack=%0d err=%0d want ack=1 err=0", na, ne); n_fail++; end
        n_checks++;
        if (rd !== 32'h0BADCAFE) begin $display("FAIL alias_data: got %h want 0badcafe", rd); n_fail++; end
        run_access(0, 1'b1, 32'h00001000, 4'b0110, 32'h11223344, t, na, ne, rd);
        n_checks++;
        if (na !== 1 || ne !== 0) begin $display("FAIL rawmask_term: got ack=%0d err=%0d want ack=1 err=0", na, ne); n_fail++; end
        run_access(0, 1'b0, 32'h0, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (rd !== 32'h0B2233FE) begin $display("FAIL rawmask_data: got %h want 0b2233fe", rd); n_fail++; end
`endif
    endtask

    task automatic test_reset_mid;
        int t, na, ne, seen; logic [31:0] rd;
        seen = 0;
        run_access(1, 1'b1, 32'h30, 4'b1111, 32'hA5A55A5A, t, na, ne, rd);
        run_access(1, 1'b0, 32'h30, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (rd !== 32'hA5A55A5A) begin $display("FAIL rstmid_pre: got %h want a5a55a5a", rd); n_fail++; end
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 4'b1111; we[1] = 1'b1;
        addr[1] = 32'h30; wdat[1] = 32'hFFFF0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin $display("FAIL rstmid_term: got ack=%b err=%b want 0 0", ack[1], err[1]); n_fail++; end
        n_checks++;
        if (rdat[1] !== 32'h0) begin $display("FAIL rstmid_dat: got %h want 0", rdat[1]); n_fail++; end
        rst = 1'b0;
        cyc[1] = 1'b0; stb[1] = 4'b0000; we[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin $display("FAIL rstmid_late_term: got %0d termination cycles want 0", seen); n_fail++; end
        run_access(1, 1'b0, 32'h30, 4'b1111, 32'h0, t, na, ne, rd);
        n_checks++;
        if (t !== 4) begin $display("FAIL rstmid_idle_latency: got %0d want 4", t); n_fail++; end
        n_checks++;
        if (rd !== 32'hA5A55A5A) begin $display("FAIL rstmid_mem: got %h want a5a55a5a", rd); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_abort();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
